// File: rtl/board_pkg.sv
// board_pkg: shared definitions for the board_grid block.
//   stateType - fill-sweep controller states (IDLE, FILL)
//   clog2     - ceiling log2, usable in parameter expressions
package board_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } stateType;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < value) result = i + 1;
      return result;
   endfunction

endpackage

// File: rtl/board_occupancy.sv
// board_occupancy: running count of nonzero cells in board_grid.
// Ports:
//   clk, reset    - clock, async active-high reset (count -> 0)
//   restart       - first cell of a sweep; count restarts from that cell alone
//   wrStrobe      - a cell is being written this cycle
//   oldValue      - value the cell holds before the write
//   newValue      - value being written
//   occupied      - number of nonzero cells, registered
module board_occupancy
   import board_pkg::*;
#(
   parameter int N      = 64,
   parameter int CELL_W = 2,
   localparam int CW    = clog2(N + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              restart,
   input  logic              wrStrobe,
   input  logic [CELL_W-1:0] oldValue,
   input  logic [CELL_W-1:0] newValue,
   output logic [CW-1:0]     occupied
);

   logic oldNz;
   logic newNz;

   assign oldNz = (oldValue != '0);
   assign newNz = (newValue != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         occupied <= '0;
      end else if (restart) begin
         occupied <= newNz ? CW'(1) : '0;
      end else if (wrStrobe) begin
         if (newNz && !oldNz)      occupied <= occupied + CW'(1);
         else if (!newNz && oldNz) occupied <= occupied - CW'(1);
      end
   end

endmodule

// File: rtl/board_grid.sv
// board_grid: WIDTH x HEIGHT grid of CELL_W-bit cells with NUM_RD read ports,
// one write port and a bulk fill sweep (one cell per cycle).
// Optional macro BOARD_GRID_COUNT_EN adds the "occupied" count output.
// Ports:
//   clk, reset              - clock, async active-high reset (starts a 0-fill sweep)
//   rd_en/rd_x/rd_y         - per-port read request and packed coordinates
//   rd_data/rd_valid        - packed read data and strobe, one cycle after request
//   wr_en/wr_x/wr_y/wr_value- single write port
//   wr_drop                 - one-cycle pulse when a write is discarded
//   clr_req/clr_value       - request a fill of every cell with clr_value
//   busy                    - fill sweep in progress
//   occupied                - (BOARD_GRID_COUNT_EN) count of nonzero cells
module board_grid
   import board_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int HEIGHT = 8,
   parameter int CELL_W = 2,
   parameter int NUM_RD = 2,
   localparam int XW    = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH),
   localparam int YW    = (clog2(HEIGHT) < 1) ? 1 : clog2(HEIGHT),
   localparam int N     = WIDTH * HEIGHT,
   localparam int AW    = (clog2(N) < 1) ? 1 : clog2(N)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD-1:0]        rd_en,
   input  logic [NUM_RD*XW-1:0]     rd_x,
   input  logic [NUM_RD*YW-1:0]     rd_y,
   output logic [NUM_RD*CELL_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_valid,
   input  logic                     wr_en,
   input  logic [XW-1:0]            wr_x,
   input  logic [YW-1:0]            wr_y,
   input  logic [CELL_W-1:0]        wr_value,
   output logic                     wr_drop,
   input  logic                     clr_req,
   input  logic [CELL_W-1:0]        clr_value,
   output logic                     busy
`ifdef BOARD_GRID_COUNT_EN
   ,output logic [clog2(N + 1)-1:0] occupied
`endif
);

   // Storage has no reset; the post-reset sweep clears it.
   logic [CELL_W-1:0] cells [N];

   stateType          state;
   logic [CELL_W-1:0] fillValue;
   logic [AW-1:0]     fillIndex;

   logic              wrInRange;
   logic [AW-1:0]     wrIndex;
   logic              wrAccept;

   logic [NUM_RD-1:0] rdInRange;
   logic [AW-1:0]     rdIndex [NUM_RD];

   assign wrInRange = (int'(wr_x) < WIDTH) && (int'(wr_y) < HEIGHT);
   assign wrIndex   = AW'(int'(wr_y) * WIDTH + int'(wr_x));
   assign wrAccept  = wr_en && (state == IDLE) && wrInRange;

   always_comb begin
      for (int k = 0; k < NUM_RD; k++) begin
         rdInRange[k] = (int'(rd_x[k*XW +: XW]) < WIDTH) && (int'(rd_y[k*YW +: YW]) < HEIGHT);
         rdIndex[k]   = AW'(int'(rd_y[k*YW +: YW]) * WIDTH + int'(rd_x[k*XW +: XW]));
      end
   end

   // The sweep owns the array while busy; user writes only land in IDLE.
   always_ff @(posedge clk) begin
      if (state == FILL)  cells[fillIndex] <= fillValue;
      else if (wrAccept)  cells[wrIndex]   <= wr_value;
   end

   // Reset lands in FILL so the array is zeroed by a normal sweep.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= FILL;
         fillValue <= '0;
         fillIndex <= '0;
         busy      <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (clr_req) begin
                  state     <= FILL;
                  fillValue <= clr_value;
                  fillIndex <= '0;
                  busy      <= 1'b1;
               end
            end
            FILL: begin
               // clr_req is deliberately not looked at here: no restart, no queueing.
               fillIndex <= fillIndex + AW'(1);
               if (fillIndex == AW'(N - 1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
         endcase
      end
   end

   // Reads sample the array before this edge's write lands (read-first).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_valid <= '0;
         rd_data  <= '0;
         wr_drop  <= 1'b0;
      end else begin
         wr_drop <= wr_en && ((state == FILL) || !wrInRange);
         for (int k = 0; k < NUM_RD; k++) begin
            rd_valid[k] <= rd_en[k] && (state == IDLE);
            if (rd_en[k] && (state == IDLE))
               rd_data[k*CELL_W +: CELL_W] <= rdInRange[k] ? cells[rdIndex[k]] : '0;
         end
      end
   end

`ifdef BOARD_GRID_COUNT_EN
   // Sweep writes count only the new value; the old contents are being discarded.
   logic              occRestart;
   logic              occStrobe;
   logic [CELL_W-1:0] occOld;
   logic [CELL_W-1:0] occNew;

   assign occRestart = (state == FILL) && (fillIndex == '0);
   assign occStrobe  = (state == FILL) || wrAccept;
   assign occOld     = (state == FILL) ? '0 : cells[wrIndex];
   assign occNew     = (state == FILL) ? fillValue : wr_value;

   board_occupancy #(
      .N      (N),
      .CELL_W (CELL_W)
   ) occ (
      .clk      (clk),
      .reset    (reset),
      .restart  (occRestart),
      .wrStrobe (occStrobe),
      .oldValue (occOld),
      .newValue (occNew),
      .occupied (occupied)
   );
`endif

endmodule

// File: tb/tb_board_grid.sv
`timescale 1ns/1ps
module tb_board_grid;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   // 8x8 default instance
   logic [1:0] rdEn = '0;
   logic [5:0] rdX = '0, rdY = '0;
   logic [3:0] rdData;
   logic [1:0] rdValid;
   logic       wrEn = 1'b0;
   logic [2:0] wrX = '0, wrY = '0;
   logic [1:0] wrValue = '0;
   logic       wrDrop;
   logic       clrReq = 1'b0;
   logic [1:0] clrValue = '0;
   logic       busy;

   // 5x6 instance: coordinates can exceed the grid
   logic [1:0] orRdEn = '0;
   logic [5:0] orRdX = '0, orRdY = '0;
   logic [3:0] orRdData;
   logic [1:0] orRdValid;
   logic       orWrEn = 1'b0;
   logic [2:0] orWrX = '0, orWrY = '0;
   logic [1:0] orWrValue = '0;
   logic       orWrDrop;
   logic       orBusy;

`ifdef BOARD_GRID_COUNT_EN
   logic [6:0] occupied;
   logic [4:0] orOccupied;
`endif

   board_grid dut (
      .clk(clk), .reset(reset),
      .rd_en(rdEn), .rd_x(rdX), .rd_y(rdY), .rd_data(rdData), .rd_valid(rdValid),
      .wr_en(wrEn), .wr_x(wrX), .wr_y(wrY), .wr_value(wrValue), .wr_drop(wrDrop),
      .clr_req(clrReq), .clr_value(clrValue), .busy(busy)
`ifdef BOARD_GRID_COUNT_EN
      , .occupied(occupied)
`endif
   );

   board_grid #(.WIDTH(5), .HEIGHT(6)) dutOr (
      .clk(clk), .reset(reset),
      .rd_en(orRdEn), .rd_x(orRdX), .rd_y(orRdY), .rd_data(orRdData), .rd_valid(orRdValid),
      .wr_en(orWrEn), .wr_x(orWrX), .wr_y(orWrY), .wr_value(orWrValue), .wr_drop(orWrDrop),
      .clr_req(1'b0), .clr_value(2'd0), .busy(orBusy)
`ifdef BOARD_GRID_COUNT_EN
      , .occupied(orOccupied)
`endif
   );

   int checks = 0;
   int failures = 0;

   // per-port expected read data: 0,1 = 8x8 ports, 2,3 = 5x6 ports
   logic [1:0] q [4][$];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // scoreboard: every valid strobe must match the oldest pending expectation
   initial begin
      logic [3:0] vAll;
      logic [7:0] dAll;
      logic [1:0] e;
      forever begin
         @(negedge clk);
         vAll = {orRdValid, rdValid};
         dAll = {orRdData, rdData};
         for (int k = 0; k < 4; k++) begin
            if (vAll[k]) begin
               if (q[k].size() == 0) begin
                  check($sformatf("unexpected_valid_p%0d", k), 1, 0);
               end else begin
                  e = q[k].pop_front();
                  check($sformatf("rd_data_p%0d", k), int'(dAll[k*2 +: 2]), int'(e));
               end
            end
         end
      end
   end

   typedef struct {
      bit       sel;   // 0: 8x8, 1: 5x6
      bit       wr;
      int       wx, wy, wv;
      bit [1:0] rd;
      int       r0x, r0y, r1x, r1y;
      int       e0, e1;
      bit       eDrop;
   } vecT;

   task automatic idleInputs();
      rdEn = '0; wrEn = 1'b0; orRdEn = '0; orWrEn = 1'b0; clrReq = 1'b0;
   endtask

   task automatic applyVec(input vecT v);
      idleInputs();
      if (!v.sel) begin
         wrEn = v.wr; wrX = 3'(v.wx); wrY = 3'(v.wy); wrValue = 2'(v.wv);
         rdEn = v.rd; rdX = {3'(v.r1x), 3'(v.r0x)}; rdY = {3'(v.r1y), 3'(v.r0y)};
         if (v.rd[0]) q[0].push_back(2'(v.e0));
         if (v.rd[1]) q[1].push_back(2'(v.e1));
      end else begin
         orWrEn = v.wr; orWrX = 3'(v.wx); orWrY = 3'(v.wy); orWrValue = 2'(v.wv);
         orRdEn = v.rd; orRdX = {3'(v.r1x), 3'(v.r0x)}; orRdY = {3'(v.r1y), 3'(v.r0y)};
         if (v.rd[0]) q[2].push_back(2'(v.e0));
         if (v.rd[1]) q[3].push_back(2'(v.e1));
      end
   endtask

   // read all 64 cells of the 8x8 instance, port 1 walking backwards
   task automatic readAll(input int v);
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         rdEn = 2'b11;
         rdX  = {3'(7 - i % 8), 3'(i % 8)};
         rdY  = {3'(7 - i / 8), 3'(i / 8)};
         q[0].push_back(2'(v));
         q[1].push_back(2'(v));
      end
      @(negedge clk);
      rdEn = '0;
      repeat (2) @(negedge clk);
   endtask

   // assert reset, check async outputs, release and count busy cycles
   task automatic resetSweep();
      int n;
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("reset_busy", int'(busy), 1);
      check("reset_rd_valid", int'(rdValid), 0);
      check("reset_rd_data", int'(rdData), 0);
      check("reset_wr_drop", int'(wrDrop), 0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      n = 0;
      while (busy && n < 200) begin
         n++;
         @(negedge clk);
      end
      check("reset_busy_cycles", n, 64);
   endtask

   task automatic writeCell(input int x, input int y, input int v);
      @(negedge clk);
      wrEn = 1'b1; wrX = 3'(x); wrY = 3'(y); wrValue = 2'(v);
      @(negedge clk);
      wrEn = 1'b0;
   endtask

   vecT vecs [16];

   initial begin
      int busyCnt;
      int pending;

      vecs[0]  = '{0, 1, 3, 5, 2, 2'b00, 0, 0, 0, 0, 0, 0, 0};
      vecs[1]  = '{0, 0, 0, 0, 0, 2'b11, 3, 5, 3, 5, 2, 2, 0};
      vecs[2]  = '{0, 1, 1, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0};
      vecs[3]  = '{0, 1, 1, 1, 3, 2'b11, 1, 1, 3, 5, 1, 2, 0};
      vecs[4]  = '{0, 0, 0, 0, 0, 2'b11, 1, 1, 0, 0, 3, 0, 0};
      vecs[5]  = '{0, 1, 7, 7, 3, 2'b11, 0, 7, 7, 7, 0, 0, 0};
      vecs[6]  = '{0, 0, 0, 0, 0, 2'b11, 7, 7, 7, 0, 3, 0, 0};
      vecs[7]  = '{0, 1, 0, 0, 2, 2'b10, 0, 0, 1, 1, 0, 3, 0};
      vecs[8]  = '{0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 2, 0, 0};
      vecs[9]  = '{1, 1, 4, 5, 2, 2'b00, 0, 0, 0, 0, 0, 0, 0};
      vecs[10] = '{1, 1, 0, 1, 3, 2'b00, 0, 0, 0, 0, 0, 0, 0};
      vecs[11] = '{1, 1, 7, 0, 3, 2'b00, 0, 0, 0, 0, 0, 0, 1};
      vecs[12] = '{1, 1, 0, 6, 3, 2'b00, 0, 0, 0, 0, 0, 0, 1};
      vecs[13] = '{1, 0, 0, 0, 0, 2'b11, 4, 5, 2, 1, 2, 0, 0};
      vecs[14] = '{1, 0, 0, 0, 0, 2'b11, 5, 0, 4, 6, 0, 0, 0};
      vecs[15] = '{1, 0, 0, 0, 0, 2'b11, 0, 1, 0, 5, 3, 0, 0};

      // power-up reset and sweep, then every cell reads 0
      resetSweep();
      readAll(0);

`ifdef BOARD_GRID_COUNT_EN
      check("occ_after_reset", int'(occupied), 0);
      writeCell(0, 1, 1);
      writeCell(0, 2, 2);
      writeCell(0, 3, 3);
      check("occ_three", int'(occupied), 3);
      writeCell(0, 2, 0);
      check("occ_two", int'(occupied), 2);
      writeCell(0, 1, 0);
      writeCell(0, 3, 0);
      check("occ_zero", int'(occupied), 0);
`endif

      // table: writes, read-first, dual port, out-of-range on the 5x6 grid
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         applyVec(vecs[i]);
         @(posedge clk);
         #1;
         check($sformatf("wr_drop_v%0d", i), int'(vecs[i].sel ? orWrDrop : wrDrop), int'(vecs[i].eDrop));
      end
      @(negedge clk);
      idleInputs();
      repeat (2) @(negedge clk);
      check("rd_data_hold", int'(rdData), 4'b1110);
      check("rd_valid_idle", int'(rdValid), 0);
`ifdef BOARD_GRID_COUNT_EN
      check("occ_table", int'(occupied), 4);
      check("occ_table_or", int'(orOccupied), 2);
`endif

      // fill with 1; same-cycle write is overwritten, writes and clr during busy
      @(negedge clk);
      clrReq = 1'b1; clrValue = 2'd1;
      wrEn = 1'b1; wrX = 3'd4; wrY = 3'd4; wrValue = 2'd3;
      @(negedge clk);
      clrReq = 1'b0; wrEn = 1'b0;
      busyCnt = 0;
      for (int c = 0; c < 200 && busy; c++) begin
         busyCnt++;
         case (c)
            0: begin
               check("wr_drop_with_clr", int'(wrDrop), 0);
               wrEn = 1'b1; wrX = 3'd2; wrY = 3'd2; wrValue = 2'd3;
               rdEn = 2'b01; rdX = '0; rdY = '0;
            end
            1: begin
               check("wr_drop_busy", int'(wrDrop), 1);
               check("rd_valid_busy", int'(rdValid), 0);
               check("rd_data_busy_hold", int'(rdData), 4'b1110);
               wrEn = 1'b0; rdEn = '0;
               clrReq = 1'b1; clrValue = 2'd2;
            end
            2: begin
               check("wr_drop_one_cycle", int'(wrDrop), 0);
               clrReq = 1'b0;
            end
            default: ;
         endcase
         @(negedge clk);
      end
      check("clr_busy_cycles", busyCnt, 64);
      repeat (3) @(negedge clk);
      check("no_restart", int'(busy), 0);
      readAll(1);
`ifdef BOARD_GRID_COUNT_EN
      check("occ_full", int'(occupied), 64);
`endif

      // reset mid-sweep: abandon fill of 3, restart from 0 with 0
      @(negedge clk);
      clrReq = 1'b1; clrValue = 2'd3;
      @(negedge clk);
      clrReq = 1'b0;
      repeat (10) @(negedge clk);
      resetSweep();
      readAll(0);
`ifdef BOARD_GRID_COUNT_EN
      check("occ_mid_reset", int'(occupied), 0);
      check("occ_mid_reset_or", int'(orOccupied), 0);
`endif

      repeat (3) @(negedge clk);
      pending = 0;
      for (int k = 0; k < 4; k++) pending += q[k].size();
      check("scoreboard_drained", pending, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // global watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/board_grid.md
BOARD_GRID -- requirements
Module: board_grid

Interface
REQ-001 SHALL take parameter WIDTH, default 8, number of columns (x), minimum 2.
REQ-002 SHALL take parameter HEIGHT, default 8, number of rows (y), minimum 2.
REQ-003 SHALL take parameter CELL_W, default 2, bits per cell.
REQ-004 SHALL take parameter NUM_RD, default 2, number of independent read ports.
REQ-005 SHALL use derived widths XW=max(1,clog2(WIDTH)), YW=max(1,clog2(HEIGHT)), N=WIDTH*HEIGHT.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 rd_en  input  NUM_RD  per-port read request.
REQ-009 rd_x / rd_y  input  NUM_RD*XW / NUM_RD*YW  packed read coordinates, port k in slice k.
REQ-010 rd_data  output  NUM_RD*CELL_W  packed read data.
REQ-011 rd_valid  output  NUM_RD  per-port data-valid strobe.
REQ-012 wr_en, wr_x (XW), wr_y (YW), wr_value (CELL_W)  input  single write port.
REQ-013 wr_drop  output  1  pulses when an issued write is discarded.
REQ-014 clr_req  input  1  and clr_value  input  CELL_W: bulk fill request and fill value.
REQ-015 busy  output  1  high while a fill sweep is in progress.

Function
REQ-016 Cell (x,y) SHALL be stored at linear index y*WIDTH+x.
REQ-017 Reads: rd_en[k] in cycle t SHALL give rd_valid[k]=1 and rd_data slice k in cycle t+1; otherwise rd_valid[k]=0 and rd_data holds its last value.
REQ-018 An in-range read SHALL return the cell contents before any same-cycle write (read-first); x>=WIDTH or y>=HEIGHT SHALL return 0 with rd_valid=1.
REQ-019 While busy=1, reads SHALL return rd_valid=0.
REQ-020 A write SHALL update the cell at the clock edge where wr_en=1, busy=0 and the coordinates are in range.
REQ-021 wr_en=1 with busy=1 or out-of-range coordinates SHALL leave storage unchanged and set wr_drop=1 for exactly the next cycle.
REQ-022 The FSM SHALL have two states: IDLE and FILL; IDLE->FILL on clr_req=1 in IDLE, latching clr_value; FILL->IDLE after index N-1 is written.
REQ-023 FILL SHALL write one cell per cycle at indices 0..N-1; busy SHALL be high for exactly N cycles, starting the cycle after acceptance.
REQ-024 clr_req while in FILL SHALL be ignored, with no restart and no queueing.
REQ-025 Simultaneous wr_en and clr_req in IDLE: the write SHALL be performed, then overwritten by the sweep.

Reset
REQ-026 reset SHALL force state=FILL, fill value=0, index=0, busy=1, rd_valid=0, rd_data=0 and wr_drop=0 asynchronously; the sweep SHALL start on the first clock edge after deassertion.
REQ-027 Storage SHALL NOT be reset directly; it SHALL be cleared only by the post-reset sweep.
REQ-028 Reset asserted mid-sweep SHALL abandon that sweep and restart at index 0 with fill value 0.

Configuration
REQ-029 With macro BOARD_GRID_COUNT_EN defined, the block SHALL add output occupied (clog2(N+1) bits), the count of cells !=0, valid whenever busy=0.
REQ-030 occupied SHALL update in the cycle after each accepted write, using old versus new value; it SHALL be 0 at sweep start and increment per nonzero cell written.
REQ-031 Without BOARD_GRID_COUNT_EN, the port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-032 Package board_pkg SHALL hold the state enum (IDLE, FILL) and a clog2 helper function.
REQ-033 The occupancy counter SHALL be sub-module board_occupancy, instantiated only under BOARD_GRID_COUNT_EN; all other logic SHALL be flat.

Verification
REQ-034 Reset, then 64 cycles with default parameters -> busy=1 for exactly 64 cycles; a subsequent read of every cell returns 0.
REQ-035 Write (3,5)=2, then read (3,5) on ports 0 and 1 in the next cycle -> both ports return 2 with rd_valid one cycle later.
REQ-036 Same-cycle write (1,1)=3 and read (1,1), old value 1 -> read returns 1; a read in the following cycle returns 3.
REQ-037 clr_req with clr_value=1, write issued during busy, second clr_req during busy -> wr_drop pulses, busy lasts 64 cycles, all cells read 1.
REQ-038 Read (8,0) and write (0,9) -> read returns 0 with rd_valid=1; wr_drop=1 and storage unchanged.
REQ-039 With BOARD_GRID_COUNT_EN: after reset, write 3 cells nonzero, then overwrite one with 0 -> occupied=3, then 2; reset mid-sweep -> occupied=0 and sweep restarts at 0.
